// File: rtl/counter_sequencer.sv
// Run/hold/done counter sequencer with one-shot and periodic modes.
// Ports: clock, reset(n), start/stop/pause/mode/period in; count/tick/busy/done/err/state out.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           cur;
  state_t           nxt;
  logic [WIDTH-1:0] per_q;
  logic             mode_q;
  logic             go;
  logic             bad;
  logic             last;
  logic             adv;

  assign go   = start && (period != '0);
  assign bad  = start && (period == '0);
  assign last = (count == per_q - ONE);
  // counting edge: no higher-priority command and not paused
  assign adv  = !stop && !start && !pause && (cur == RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (stop) begin
      nxt = IDLE;
    end else if (go) begin
      nxt = RUN;
    end else if (!bad) begin
      unique case (cur)
        RUN: begin
          if (pause)     nxt = HOLD;
          else if (last) nxt = mode_q ? RUN : DONE;
        end
        HOLD: begin
          if (!pause) nxt = RUN;
        end
        default: nxt = cur;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      tick   <= 1'b0;
      err    <= 1'b0;
      per_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      tick <= 1'b0;
      err  <= 1'b0;
      if (stop) begin
        count <= '0;
      end else if (go) begin
        count  <= '0;
        per_q  <= period;
        mode_q <= mode;
      end else if (bad) begin
        err <= 1'b1;
      end else if (adv) begin
        if (last) begin
          count <= '0;
          tick  <= 1'b1;
        end else begin
          count <= count + ONE;
        end
      end
    end
  end

  always_comb begin
    busy  = (cur == RUN) || (cur == HOLD);
    done  = (cur == DONE);
    state = cur;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized self-checking bench for counter_sequencer.
// Reference model tracks state/count with plain modular arithmetic.
module tb_counter_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       pause = 1'b0;
  logic       mode  = 1'b0;
  logic [3:0] period = '0;
  logic [3:0] count;
  logic       tick;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] state;

  int passed = 0;
  int total  = 0;

  // model: ms 0=IDLE 1=RUN 2=HOLD 3=DONE
  int   ms = 0;
  int   mc = 0;
  int   mp = 0;
  int   mm = 0;
  logic et = 1'b0;
  logic ee = 1'b0;

  counter_sequencer #(.WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .mode  (mode),
    .period(period),
    .count (count),
    .tick  (tick),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .state (state)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] expv();
    logic [1:0] s;
    logic [3:0] c;
    s = 2'(ms);
    c = 4'(mc);
    return {s, c, et, (ms == 1 || ms == 2), (ms == 3), ee};
  endfunction

  function automatic logic [9:0] gotv();
    return {state, count, tick, busy, done, err};
  endfunction

  task automatic model_reset();
    ms = 0; mc = 0; mp = 0; mm = 0; et = 0; ee = 0;
  endtask

  task automatic cycle(input logic st, input logic sp, input logic pa,
                       input logic md, input logic [3:0] pr);
    start = st; stop = sp; pause = pa; mode = md; period = pr;
    @(posedge clock);
    et = 0; ee = 0;
    if (sp) begin
      ms = 0; mc = 0;
    end else if (st && pr != 0) begin
      mp = int'(pr); mm = int'(md); mc = 0; ms = 1;
    end else if (st) begin
      ee = 1;
    end else if (ms == 1 && pa) begin
      ms = 2;
    end else if (ms == 1) begin
      mc = (mc + 1) % mp;
      if (mc == 0) begin
        et = 1;
        if (mm == 0) ms = 3;
      end
    end else if (ms == 2 && !pa) begin
      ms = 1;
    end
    #1;
    start = 0; stop = 0; pause = 0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (gotv() !== 10'd0) $display("FAIL reset_hold got %h exp %h", gotv(), 10'd0);
    else passed++;
    @(posedge clock); #3;
    reset = 1'b1;
    model_reset();
    cycle(0, 0, 1, 0, 4'd5);
    total++;
    if (gotv() !== expv()) $display("FAIL reset_idle got %h exp %h", gotv(), expv());
    else passed++;
  endtask

  task automatic test_oneshot();
    cycle(1, 0, 0, 0, 4'd4);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (gotv() !== expv()) $display("FAIL oneshot_%0d got %h exp %h", i, gotv(), expv());
      else passed++;
      if (i == 3) begin
        total++;
        if ({count, state} !== {4'd3, 2'd1}) $display("FAIL oneshot_c3 got %h exp %h", {count, state}, {4'd3, 2'd1});
        else passed++;
      end
      if (i == 4) begin
        total++;
        if ({count, tick, state, done} !== {4'd0, 1'b1, 2'd3, 1'b1})
          $display("FAIL oneshot_wrap got %h exp %h", {count, tick, state, done}, {4'd0, 1'b1, 2'd3, 1'b1});
        else passed++;
      end
      cycle(0, 0, 0, 0, 4'(i));
    end
  endtask

  task automatic test_periodic();
    int ticks = 0;
    int nbusy = 0;
    cycle(1, 0, 0, 1, 4'd3);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 0, 4'd0);
      ticks += int'(tick);
      nbusy += int'(!busy);
      total++;
      if (gotv() !== expv()) $display("FAIL periodic_%0d got %h exp %h", i, gotv(), expv());
      else passed++;
    end
    total++;
    if (ticks != 3 || nbusy != 0) $display("FAIL periodic_ticks got %0d/%0d exp 3/0", ticks, nbusy);
    else passed++;
  endtask

  task automatic test_pause();
    cycle(1, 0, 0, 0, 4'd5);
    cycle(0, 0, 0, 0, 4'd0);
    cycle(0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 4'd0);
      total++;
      if ({count, state, tick} !== {4'd2, 2'd2, 1'b0})
        $display("FAIL pause_hold_%0d got %h exp %h", i, {count, state, tick}, {4'd2, 2'd2, 1'b0});
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 4'd0);
      total++;
      if (gotv() !== expv()) $display("FAIL pause_resume_%0d got %h exp %h", i, gotv(), expv());
      else passed++;
    end
    total++;
    if ({tick, count, done} !== {1'b1, 4'd0, 1'b1})
      $display("FAIL pause_tick got %h exp %h", {tick, count, done}, {1'b1, 4'd0, 1'b1});
    else passed++;
  endtask

  task automatic test_start_stop();
    cycle(1, 0, 0, 0, 4'd8);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 4'd0);
    cycle(1, 1, 0, 0, 4'd8);
    total++;
    if (gotv() !== 10'd0) $display("FAIL startstop got %h exp %h", gotv(), 10'd0);
    else passed++;
    cycle(1, 0, 0, 1, 4'd0);
    total++;
    if ({err, state, count} !== {1'b1, 2'd0, 4'd0})
      $display("FAIL zero_period got %h exp %h", {err, state, count}, {1'b1, 2'd0, 4'd0});
    else passed++;
    cycle(0, 0, 0, 0, 4'd0);
    total++;
    if (gotv() !== expv()) $display("FAIL err_pulse got %h exp %h", gotv(), expv());
    else passed++;
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 0, 0, 4'd10);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 4'd0);
    total++;
    if (count !== 4'd6) $display("FAIL pre_reset got %0d exp 6", count);
    else passed++;
    #2 reset = 1'b0;
    #1;
    model_reset();
    total++;
    if (gotv() !== 10'd0) $display("FAIL async_reset got %h exp %h", gotv(), 10'd0);
    else passed++;
    @(posedge clock); #3;
    reset = 1'b1;
    cycle(0, 0, 0, 0, 4'd0);
    cycle(0, 0, 1, 0, 4'd0);
    total++;
    if (gotv() !== expv()) $display("FAIL post_reset_idle got %h exp %h", gotv(), expv());
    else passed++;
  endtask

  task automatic test_p1();
    cycle(1, 0, 0, 1, 4'd1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 4'd0);
      total++;
      if ({tick, count, state} !== {1'b1, 4'd0, 2'd1})
        $display("FAIL p1_%0d got %h exp %h", i, {tick, count, state}, {1'b1, 4'd0, 2'd1});
      else passed++;
    end
    cycle(0, 1, 0, 0, 4'd0);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(7) == 0), ($urandom_range(19) == 0),
            ($urandom_range(3) == 0), 1'($urandom), 4'($urandom));
      total++;
      if (gotv() !== expv()) begin
        bad++;
        if (bad < 10) $display("FAIL random_%0d got %h exp %h", i, gotv(), expv());
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_start_stop();
    test_async_reset();
    test_p1();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
